// File: rtl/window_3x3_stream.sv
// window_3x3_stream: raster pixel stream to 3x3 neighbourhood generator.
// Two circular RAM line buffers (depth IMG_W) supply the two previous lines;
// a two-stage pipeline forms the 3x3 window and flags interior windows only.
// Optional feature macro: WINDOW_3X3_STREAM_COORD_EN adds out_x/out_y window
// centre coordinates.
module window_3x3_stream #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 320,
  parameter int unsigned IMG_H  = 240,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9
) (
  input  logic              clock,
  input  logic              frame_reset_n,
  input  logic              frame_start,
  input  logic [DATA_W-1:0] datain,
  input  logic              datain_en,
  output logic [DATA_W-1:0] data00,
  output logic [DATA_W-1:0] data01,
  output logic [DATA_W-1:0] data02,
  output logic [DATA_W-1:0] data10,
  output logic [DATA_W-1:0] data11,
  output logic [DATA_W-1:0] data12,
  output logic [DATA_W-1:0] data20,
  output logic [DATA_W-1:0] data21,
  output logic [DATA_W-1:0] data22,
  output logic              data_valid,
  output logic              frame_done,
  output logic              overrun
`ifdef WINDOW_3X3_STREAM_COORD_EN
  ,
  output logic [XW-1:0]     out_x,
  output logic [YW-1:0]     out_y
`endif
);

  localparam int unsigned AW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_MIN  = XW'(2);
  localparam logic [YW-1:0] Y_MIN  = YW'(2);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [XW-1:0]     cur_x_c;
  logic [YW-1:0]     cur_y_c;
  logic              running_c;
  logic              accept_c;
  logic              ignored_c;
  logic              x_last_c;
  logic              y_last_c;
  logic [AW-1:0]     addr_c;

  logic [DATA_W-1:0] lb1 [IMG_W];
  logic [DATA_W-1:0] lb2 [IMG_W];

  logic              s1_en;
  logic [XW-1:0]     s1_x;
  logic [YW-1:0]     s1_y;
  logic [DATA_W-1:0] s1_top;
  logic [DATA_W-1:0] s1_mid;
  logic [DATA_W-1:0] s1_bot;

  // Frame state register
  always_ff @(posedge clock or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and acceptance; frame_start restarts at (0,0) in the same cycle
  always_comb begin
    state_d   = state_q;
    cur_x_c   = x_q;
    cur_y_c   = y_q;
    running_c = (state_q == ST_RUN);
    if (frame_start) begin
      state_d   = ST_RUN;
      cur_x_c   = '0;
      cur_y_c   = '0;
      running_c = 1'b1;
    end
    accept_c  = datain_en && running_c;
    ignored_c = datain_en && !running_c;
    x_last_c  = (cur_x_c == X_LAST);
    y_last_c  = (cur_y_c == Y_LAST);
    if (accept_c && x_last_c && y_last_c) begin
      state_d = ST_DONE;
    end
  end

  assign addr_c = cur_x_c[AW-1:0];

  // Position counters; they freeze on the last pixel of the frame
  always_ff @(posedge clock or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else if (accept_c && !(x_last_c && y_last_c)) begin
      if (x_last_c) begin
        x_q <= '0;
        y_q <= cur_y_c + YW'(1);
      end else begin
        x_q <= cur_x_c + XW'(1);
        y_q <= cur_y_c;
      end
    end else begin
      x_q <= cur_x_c;
      y_q <= cur_y_c;
    end
  end

  // Sticky overrun: pixel offered after the frame completed
  always_ff @(posedge clock or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      overrun <= 1'b0;
    end else begin
      overrun <= (overrun && !frame_start) || ignored_c;
    end
  end

  // Line buffers (read-before-write) and stage-1 column capture
  always_ff @(posedge clock) begin
    if (accept_c) begin
      s1_top      <= lb2[addr_c];
      s1_mid      <= lb1[addr_c];
      s1_bot      <= datain;
      lb1[addr_c] <= datain;
      lb2[addr_c] <= lb1[addr_c];
    end
  end

  // Stage-1 control: enable and position of the captured column
  always_ff @(posedge clock or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      s1_en <= 1'b0;
      s1_x  <= '0;
      s1_y  <= '0;
    end else begin
      s1_en <= accept_c;
      if (accept_c) begin
        s1_x <= cur_x_c;
        s1_y <= cur_y_c;
      end
    end
  end

  // Stage 2: shift the window on each new column and flag interior windows
  always_ff @(posedge clock or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      data00     <= '0;
      data01     <= '0;
      data02     <= '0;
      data10     <= '0;
      data11     <= '0;
      data12     <= '0;
      data20     <= '0;
      data21     <= '0;
      data22     <= '0;
      data_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      data_valid <= s1_en && (s1_x >= X_MIN) && (s1_y >= Y_MIN);
      frame_done <= s1_en && (s1_x == X_LAST) && (s1_y == Y_LAST);
      if (s1_en) begin
        data00 <= data01;
        data01 <= data02;
        data02 <= s1_top;
        data10 <= data11;
        data11 <= data12;
        data12 <= s1_mid;
        data20 <= data21;
        data21 <= data22;
        data22 <= s1_bot;
      end
    end
  end

`ifdef WINDOW_3X3_STREAM_COORD_EN
  // Window centre coordinates, wrapping below zero at the frame edges
  always_ff @(posedge clock or negedge frame_reset_n) begin
    if (!frame_reset_n) begin
      out_x <= '0;
      out_y <= '0;
    end else if (s1_en) begin
      out_x <= s1_x - XW'(1);
      out_y <= s1_y - YW'(1);
    end
  end
`endif

endmodule

// File: doc/window_3x3_stream.md
Name: window_3x3_stream

Overview:
- Parametrised successor to the fixed 320-pixel, 8-bit 3x3 window generator.
- Converts a raster pixel stream into a 3x3 neighbourhood for Sobel and other kernels.
- Two internal circular RAM line buffers replace the FIFO chain. Pixel width and image size are generic.
- Tracks x/y position, flags only windows fully inside the frame, and reports frame completion and stream overrun.

Parameters:
- DATA_W, 8, pixel width in bits.
- IMG_W, 320, pixels per line; must be >= 3.
- IMG_H, 240, lines per frame; must be >= 3.
- XW, 10, x counter width; must satisfy 2^XW >= IMG_W.
- YW, 9, y counter width; must satisfy 2^YW >= IMG_H.

Ports:
- clock  in  1  single clock domain.
- frame_reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  synchronous one-cycle pulse; clears position counters and error.
- datain  in  DATA_W  input pixel, raster order.
- datain_en  in  1  qualifies datain; gaps allowed.
- data00..data02, data10..data12, data20..data22  out  DATA_W each  window taps; row 0 = oldest line, column 2 = newest pixel.
- data_valid  out  1  one-cycle pulse per interior window.
- frame_done  out  1  one-cycle pulse when the last window of the frame is output.
- overrun  out  1  sticky; an input pixel arrived beyond IMG_W*IMG_H.

Behaviour:
- Reset (frame_reset_n low, asynchronous):
  - All taps 0; data_valid, frame_done, overrun 0.
  - x=0, y=0; pipeline valid bits cleared.
  - RAM contents are not cleared.
- Position counters: accepted pixel (x,y) = pixel accepted while counters hold x,y.
  - On datain_en: x increments; at x==IMG_W-1, x wraps to 0 and y increments.
  - After pixel (IMG_W-1, IMG_H-1): counters freeze in a DONE state.
- Line buffers: two RAMs (lb1, lb2), depth IMG_W, address = x, registered read-before-write.
  - Stage 0, accepting pixel (x,y): read lb1[x]=P(x,y-1) and lb2[x]=P(x,y-2); write lb1[x]<=datain and lb2[x]<=old lb1[x].
- Stage 1: column register holds {P(x,y-2), P(x,y-1), P(x,y)}, plus x, y and an enable flag.
- Stage 2, shift on stage-1 enable only:
  - data22<=P(x,y), data21<=data22, data20<=data21.
  - Rows 1 and 0 shift the same way from their column values.
- Latency: pixel (x,y) accepted at cycle T → window centred on (x-1,y-1) on the outputs at T+2.
- data_valid at T+2 iff x>=2 and y>=2; exactly (IMG_W-2)*(IMG_H-2) pulses per frame.
- Taps hold between shifts. Windows with x<2 contain previous-line pixels, with data_valid low.
- frame_done at T+2 for pixel (IMG_W-1, IMG_H-1), coincident with the last data_valid.
- datain_en in the DONE state: pixel ignored (no RAM write, no shift), overrun set.
- frame_start handling:
  - Clears x, y, DONE and overrun.
  - In-flight stage-1/2 results still complete.
  - frame_start together with datain_en: that pixel is accepted as (0,0) of the new frame.
- Mid-frame frame_start: stale RAM data is never flagged valid because y restarts at 0.
- No backpressure; a sustained input rate of one pixel per clock is required.

Optional Feature:
- Macro WINDOW_3X3_STREAM_COORD_EN.
- When defined:
  - Adds output ports out_x (XW) and out_y (YW), reset 0.
  - They update with every stage-2 shift to the window centre (x-1, y-1).
  - When x<2 or y<2 they hold the raw (x-1) and (y-1) modulo 2^XW and 2^YW.
- When undefined: ports and registers are absent; all other behaviour is identical.

Test Plan:
1. Default reset: IMG_W=8, IMG_H=6, DATA_W=8, pixel value y*16+x, continuous datain_en.
   - First data_valid 2 cycles after pixel (2,2) is accepted.
   - Window at that pulse: data00=0x00, data11=0x11, data22=0x22.
   - 24 data_valid pulses total; frame_done coincides with window data00=0x35, data22=0x57.
2. Same image with datain_en 1-of-3 duty cycle.
   - Identical 24 windows in order; taps stable between pulses; no extra pulses.
3. frame_start after pixel (4,3), then a fresh full frame.
   - No valid window until new pixel (2,2); 24 pulses in the new frame; overrun 0.
4. Send 50 pixels (48 + 2 extra) with no frame_start.
   - overrun rises on pixel 49 and stays 1; taps unchanged after frame_done.
   - Next frame_start clears overrun.
5. Assert frame_reset_n low mid-line (x=5,y=3), asynchronously between clock edges.
   - Outputs 0 immediately; restart at (0,0) with no valid until (2,2).
6. With WINDOW_3X3_STREAM_COORD_EN and DATA_W=10, IMG_W=5, IMG_H=3, pixel value 0x3FF-(5*y+x).
   - 3 pulses with out_x=1,2,3 and out_y=1; data11 = 0x3F9, 0x3F8, 0x3F7.
